// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - PS/2 Set-2 scan-code sequence decoder with event FIFO
//
// Turns the byte stream from the PS/2 receive stage into single key events
// {ext, release, code}. It understands E0 (extended) and F0 (break) prefixes,
// drops the print-screen fake-shift codes, and collapses the 8-byte E1 Pause
// sequence into one extended make of code 77. Keyboard control/status bytes
// are reported on a separate strobe. Events are queued in a small FIFO.
//
// Optional feature macro: PS2_MODIFIER_TRACK_EN
//   defined   : mod_shift/mod_ctrl/mod_alt follow make/break of the modifier keys
//   undefined : mod_* are tied low and no tracking logic is built
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   rx_data         byte from receive stage, qualified by rx_done_stb
//   rx_done_stb     one-cycle strobe, new byte on rx_data
//   out_valid       FIFO non-empty
//   out_ready       consumer pops the head entry when out_valid & out_ready
//   out_code        head entry scan code
//   out_ext         head entry is extended (E0 or Pause)
//   out_release     head entry is a break (key up)
//   ctrl_stb        one-cycle pulse, control/status byte received
//   ctrl_code       last control/status byte, held until the next ctrl_stb
//   overflow_stb    one-cycle pulse, an event was dropped because the FIFO was full
//   mod_shift       left or right shift held
//   mod_ctrl        left or right ctrl held
//   mod_alt         left or right alt held

module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done_stb,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_code,
  output logic       out_ext,
  output logic       out_release,
  output logic       ctrl_stb,
  output logic [7:0] ctrl_code,
  output logic       overflow_stb,
  output logic       mod_shift,
  output logic       mod_ctrl,
  output logic       mod_alt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_E0,
    S_F0,
    S_E0F0,
    S_PAUSE
  } state_t;

  state_t          state;
  state_t          nxt_state;
  logic [2:0]      pause_cnt;
  logic [TW-1:0]   tmo_cnt;

  logic            push_en;
  logic            push_ext;
  logic            push_rel;
  logic [7:0]      push_code;
  logic            ctrl_hit;
  logic            is_fake_shift;
  logic            is_ctrl_byte;

  // Print-screen wraps its code in E0 12 / E0 59 (and their breaks); these
  // are not real shift presses and must not become events.
  assign is_fake_shift = (rx_data == 8'h12) || (rx_data == 8'h59);
  assign is_ctrl_byte  = rx_data inside {8'hAA, 8'hFA, 8'hEE, 8'hFE,
                                         8'hFC, 8'hFD, 8'h00, 8'hFF};

  // Sequence decode: what this byte means in the current state.
  always_comb begin
    nxt_state = state;
    push_en   = 1'b0;
    push_ext  = 1'b0;
    push_rel  = 1'b0;
    push_code = rx_data;
    ctrl_hit  = 1'b0;
    if (rx_done_stb) begin
      case (state)
        S_IDLE: begin
          if (rx_data == 8'hE0)      nxt_state = S_E0;
          else if (rx_data == 8'hF0) nxt_state = S_F0;
          else if (rx_data == 8'hE1) nxt_state = S_PAUSE;
          else if (is_ctrl_byte)     ctrl_hit  = 1'b1;
          else                       push_en   = 1'b1;
        end
        S_E0: begin
          if (rx_data == 8'hF0) begin
            nxt_state = S_E0F0;
          end else begin
            nxt_state = S_IDLE;
            push_en   = !is_fake_shift;
            push_ext  = 1'b1;
          end
        end
        S_F0: begin
          nxt_state = S_IDLE;
          push_en   = 1'b1;
          push_rel  = 1'b1;
        end
        S_E0F0: begin
          nxt_state = S_IDLE;
          push_en   = !is_fake_shift;
          push_ext  = 1'b1;
          push_rel  = 1'b1;
        end
        S_PAUSE: begin
          // Byte contents inside the Pause sequence are ignored; only the
          // count matters. The last byte emits a single extended make.
          if (pause_cnt == 3'd1) begin
            nxt_state = S_IDLE;
            push_en   = 1'b1;
            push_ext  = 1'b1;
            push_code = 8'h77;
          end
        end
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  // Sequence state, Pause byte count, inter-byte timeout, control strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pause_cnt <= 3'd0;
      tmo_cnt   <= '0;
      ctrl_stb  <= 1'b0;
      ctrl_code <= 8'h00;
    end else begin
      ctrl_stb <= ctrl_hit;
      if (ctrl_hit) ctrl_code <= rx_data;

      if (rx_done_stb) begin
        state   <= nxt_state;
        tmo_cnt <= '0;
        if (state == S_IDLE && nxt_state == S_PAUSE) pause_cnt <= 3'd7;
        else if (state == S_PAUSE)                   pause_cnt <= pause_cnt - 3'd1;
      end else if (state == S_IDLE) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TMO_LAST) begin
        // Stalled mid-sequence: abandon it without emitting anything.
        state   <= S_IDLE;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  // Event FIFO, entry = {ext, release, code}.
  logic [9:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;
  logic [9:0]    head;

  assign fifo_full = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok   = push_en && (!fifo_full || pop);
  assign head      = fifo_mem[rd_ptr];

  // Head is gated so outputs read zero while empty (including out of reset).
  assign out_code    = out_valid ? head[7:0] : 8'h00;
  assign out_release = out_valid ? head[8]   : 1'b0;
  assign out_ext     = out_valid ? head[9]   : 1'b0;

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= {push_ext, push_rel, push_code};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_stb <= 1'b0;
    end else begin
      overflow_stb <= push_en && !push_ok;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef PS2_MODIFIER_TRACK_EN
  // Left and right keys are tracked separately so releasing one side does
  // not clear the modifier while the other side is still held. Dropped
  // events still update the state so it tracks the physical keyboard.
  logic l_shift, r_shift, l_ctrl, r_ctrl, l_alt, r_alt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_shift <= 1'b0;
      r_shift <= 1'b0;
      l_ctrl  <= 1'b0;
      r_ctrl  <= 1'b0;
      l_alt   <= 1'b0;
      r_alt   <= 1'b0;
    end else if (push_en) begin
      if (!push_ext && push_code == 8'h12) l_shift <= !push_rel;
      if (!push_ext && push_code == 8'h59) r_shift <= !push_rel;
      if (!push_ext && push_code == 8'h14) l_ctrl  <= !push_rel;
      if ( push_ext && push_code == 8'h14) r_ctrl  <= !push_rel;
      if (!push_ext && push_code == 8'h11) l_alt   <= !push_rel;
      if ( push_ext && push_code == 8'h11) r_alt   <= !push_rel;
    end
  end

  assign mod_shift = l_shift || r_shift;
  assign mod_ctrl  = l_ctrl  || r_ctrl;
  assign mod_alt   = l_alt   || r_alt;
`else
  assign mod_shift = 1'b0;
  assign mod_ctrl  = 1'b0;
  assign mod_alt   = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb/tb_ps2_scancode_decoder.sv - self-checking bench for ps2_scancode_decoder
//
// Reference model interprets each completed byte sequence as a whole (a
// queue of the bytes seen so far) and keeps the expected event FIFO as a queue.

module tb_ps2_scancode_decoder;

  localparam int DEPTH = 8;
  localparam int TMO   = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done_stb;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_code;
  logic       out_ext;
  logic       out_release;
  logic       ctrl_stb;
  logic [7:0] ctrl_code;
  logic       overflow_stb;
  logic       mod_shift;
  logic       mod_ctrl;
  logic       mod_alt;

  ps2_scancode_decoder #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done_stb (rx_done_stb),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_code    (out_code),
    .out_ext     (out_ext),
    .out_release (out_release),
    .ctrl_stb    (ctrl_stb),
    .ctrl_code   (ctrl_code),
    .overflow_stb(overflow_stb),
    .mod_shift   (mod_shift),
    .mod_ctrl    (mod_ctrl),
    .mod_alt     (mod_alt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [9:0] mq[$];        // expected FIFO contents {ext, rel, code}
  logic [7:0] seq[$];       // bytes of the sequence in progress
  int         gap;
  bit         exp_ctrl_stb;
  logic [7:0] exp_ctrl_code;
  bit         exp_ovf;
  bit         ms_l, ms_r, mc_l, mc_r, ma_l, ma_r;

  function automatic bit is_ctrl(input logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'hFD, 8'h00, 8'hFF};
  endfunction

  function automatic bit is_fake(input logic [7:0] b);
    return (b == 8'h12) || (b == 8'h59);
  endfunction

  task automatic model_clear();
    mq.delete();
    seq.delete();
    gap = 0;
    exp_ctrl_stb = 0;
    exp_ctrl_code = 8'h00;
    exp_ovf = 0;
    {ms_l, ms_r, mc_l, mc_r, ma_l, ma_r} = '0;
  endtask

  // Append a byte and interpret the sequence once it is complete.
  task automatic model_byte(input logic [7:0] b, output bit ev, output logic [9:0] e);
    ev = 0;
    e  = '0;
    seq.push_back(b);
    gap = 0;
    if (seq[0] == 8'hE1) begin
      if (seq.size() == 8) begin
        ev = 1; e = {2'b10, 8'h77}; seq.delete();
      end
    end else if (seq.size() == 1) begin
      if (b != 8'hE0 && b != 8'hF0) begin
        if (is_ctrl(b)) begin
          exp_ctrl_stb = 1; exp_ctrl_code = b;
        end else begin
          ev = 1; e = {2'b00, b};
        end
        seq.delete();
      end
    end else if (seq.size() == 2) begin
      if (seq[0] == 8'hF0) begin
        ev = 1; e = {2'b01, b}; seq.delete();
      end else if (b != 8'hF0) begin
        if (!is_fake(b)) begin ev = 1; e = {2'b10, b}; end
        seq.delete();
      end
    end else begin
      if (!is_fake(b)) begin ev = 1; e = {2'b11, b}; end
      seq.delete();
    end
  endtask

  task automatic model_mods(input logic [9:0] e);
    bit mk;
    mk = !e[8];
    if (!e[9] && e[7:0] == 8'h12) ms_l = mk;
    if (!e[9] && e[7:0] == 8'h59) ms_r = mk;
    if (e[7:0] == 8'h14) begin if (e[9]) mc_r = mk; else mc_l = mk; end
    if (e[7:0] == 8'h11) begin if (e[9]) ma_r = mk; else ma_l = mk; end
  endtask

  task automatic verify();
    bit em_s, em_c, em_a;
`ifdef PS2_MODIFIER_TRACK_EN
    em_s = ms_l | ms_r; em_c = mc_l | mc_r; em_a = ma_l | ma_r;
`else
    em_s = 0; em_c = 0; em_a = 0;
`endif
    check_eq("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check_eq("out_code", out_code, mq[0][7:0]);
      check_eq("out_ext", out_ext, mq[0][9]);
      check_eq("out_release", out_release, mq[0][8]);
    end
    check_eq("ctrl_stb", ctrl_stb, exp_ctrl_stb);
    check_eq("ctrl_code", ctrl_code, exp_ctrl_code);
    check_eq("overflow_stb", overflow_stb, exp_ovf);
    check_eq("mod_shift", mod_shift, em_s);
    check_eq("mod_ctrl", mod_ctrl, em_c);
    check_eq("mod_alt", mod_alt, em_a);
  endtask

  // One clock: drive inputs (we are at a negedge), predict the edge, check.
  task automatic cycle(input bit has_byte, input logic [7:0] b, input bit ready);
    bit         pop, ev;
    logic [9:0] e;
    rx_done_stb = has_byte;
    rx_data     = has_byte ? b : 8'($urandom);
    out_ready   = ready;
    pop = (mq.size() != 0) && ready;
    ev = 0;
    e  = '0;
    exp_ctrl_stb = 0;
    exp_ovf = 0;
    if (has_byte) begin
      model_byte(b, ev, e);
    end else begin
      gap++;
      if (seq.size() != 0 && gap >= TMO) seq.delete();
    end
    if (ev) model_mods(e);
    if (pop) void'(mq.pop_front());
    if (ev) begin
      if (mq.size() < DEPTH) mq.push_back(e);
      else exp_ovf = 1;
    end
    @(negedge clk);
    verify();
  endtask

  task automatic send(input logic [7:0] b, input bit ready);
    cycle(1'b1, b, ready);
  endtask

  task automatic idle(input int n, input bit ready);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, ready);
  endtask

  logic [7:0] pool [16];

  initial begin
    pool = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'h14, 8'h11, 8'h77,
             8'h1C, 8'h75, 8'hAA, 8'hFA, 8'h00, 8'hFF, 8'h7C, 8'hF0};
    rst = 1'b1;
    rx_data = 8'h00;
    rx_done_stb = 1'b0;
    out_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_code", {out_ext, out_release, out_code}, 0);
    rst = 1'b0;
    @(negedge clk);
    verify();

    // single make, then pop
    send(8'h1C, 0);
    check_eq("t1_valid", out_valid, 1);
    check_eq("t1_word", {out_ext, out_release, out_code}, {2'b00, 8'h1C});
    idle(1, 1);
    check_eq("t1_popped", out_valid, 0);

    // extended break
    send(8'hE0, 0);
    send(8'hF0, 0);
    check_eq("t2_none_yet", out_valid, 0);
    send(8'h75, 0);
    check_eq("t2_word", {out_ext, out_release, out_code}, {2'b11, 8'h75});
    idle(2, 1);

    // Pause sequence
    send(8'hE1, 0); send(8'h14, 0); send(8'h77, 0); send(8'hE1, 0);
    send(8'hF0, 0); send(8'h14, 0); send(8'hF0, 0);
    check_eq("t3_none_yet", out_valid, 0);
    send(8'h77, 0);
    check_eq("t3_word", {out_ext, out_release, out_code}, {2'b10, 8'h77});
    idle(1, 1);
    check_eq("t3_single", out_valid, 0);

    // fake shift discarded, then control byte
    send(8'hE0, 0); send(8'h12, 0);
    check_eq("t4_fake_drop", out_valid, 0);
    send(8'hE0, 0); send(8'h7C, 0);
    check_eq("t4_word", {out_ext, out_release, out_code}, {2'b10, 8'h7C});
    idle(1, 1);
    send(8'hAA, 0);
    check_eq("t4_ctrl_stb", ctrl_stb, 1);
    check_eq("t4_ctrl_code", ctrl_code, 8'hAA);
    check_eq("t4_no_entry", out_valid, 0);
    idle(1, 0);
    check_eq("t4_ctrl_pulse", ctrl_stb, 0);

    // overflow: 9 makes into an 8-deep FIFO
    for (int i = 0; i < 9; i++) begin
      send(8'h15 + 8'(i), 0);
      if (i == 7) check_eq("t5_ovf_pre", overflow_stb, 0);
    end
    check_eq("t5_ovf", overflow_stb, 1);
    idle(1, 0);
    check_eq("t5_ovf_pulse", overflow_stb, 0);
    // push and pop in the same cycle while full
    send(8'h2A, 1);
    idle(DEPTH + 2, 1);

    // timeout abandons an E0 prefix
    send(8'hE0, 0);
    idle(TMO, 0);
    send(8'h1C, 0);
    check_eq("t6_word", {out_ext, out_release, out_code}, {2'b00, 8'h1C});
    idle(1, 1);
    // a short stall keeps the prefix
    send(8'hE0, 0);
    idle(TMO / 2, 0);
    send(8'h1C, 0);
    check_eq("t6_keep", {out_ext, out_release, out_code}, {2'b10, 8'h1C});
    idle(1, 1);

    // modifier make/break
    send(8'h12, 1);
    send(8'hF0, 1); send(8'h12, 1);
    idle(2, 1);

    // asynchronous reset mid-sequence
    send(8'h1C, 0);
    send(8'hE0, 0);
    send(8'h12, 0);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_valid", out_valid, 0);
    check_eq("rst_mid_word", {out_ext, out_release, out_code}, 0);
    check_eq("rst_mid_mods", {mod_shift, mod_ctrl, mod_alt}, 0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    send(8'h7C, 0);
    check_eq("rst_mid_after", {out_ext, out_release, out_code}, {2'b00, 8'h7C});
    idle(1, 1);

    // randomized traffic
    for (int it = 0; it < 3000; it++) begin
      logic [7:0] b;
      int         g;
      b = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
      send(b, $urandom_range(0, 9) < 6);
      g = $urandom_range(0, 99);
      if (g < 2)       idle(TMO + 3 + $urandom_range(0, 5), $urandom_range(0, 1));
      else if (g < 40) idle($urandom_range(1, 4), $urandom_range(0, 9) < 6);
    end
    idle(DEPTH + 2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
